// File: rtl/mult_seq_core.sv
// mult_seq_core: shift-and-add unsigned multiplier, one multiplier bit per clock
module mult_seq_core #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] pp,
  output logic               done,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d, pp_q, pp_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d, busy_q, busy_d, init_q, start;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    pp_d    = pp_q;
    done_d  = done_q;
    busy_d  = busy_q;
    start   = init & ~init_q;
    if (state_q == S_RUN) begin
      pp_d  = b_q[0] ? pp_q + a_q : pp_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end else if (start) begin
      a_d     = {{WIDTH{1'b0}}, a};
      b_d     = b;
      pp_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = S_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      pp_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      pp_q    <= pp_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      init_q  <= init;
    end
  end
  assign pp   = pp_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mult_seq_core.sv
// tb_mult_seq_core: directed scoreboard bench for the sequential multiplier
module tb_mult_seq_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [31:0] pp;
  logic        done, busy;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  mult_seq_core #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .init(init), .a(a), .b(b), .pp(pp), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    a    = x;
    b    = y;
    init = 1'b1;
    exp_q.push_back(32'(x) * 32'(y));
  endtask
  // n0 = edges already taken since the start edge was presented; 0 means the start edge is next
  task automatic wait_done(input int n0, input string tag);
    int          n;
    logic [31:0] e;
    n = n0;
    if (n == 0) begin
      tick();
      n = 1;
      chk({tag, "_busy_start"}, busy, 1);
      chk({tag, "_done_start"}, done, 0);
    end
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 17);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_pp"}, pp, e);
    chk({tag, "_busy_end"}, busy, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_pp", pp, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    start_op(16'd5, 16'd2);
    wait_done(0, "basic");
    repeat (5) tick();
    chk("hold_done", done, 1);
    chk("hold_busy", busy, 0);
    chk("hold_pp", pp, 10);
    init = 1'b0;
    tick();
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(0, "max");
    init = 1'b0;
    tick();
    start_op(16'h0000, 16'h1234);
    wait_done(0, "zero");
    init = 1'b0;
    tick();
    start_op(16'd3, 16'h8000);
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("hibit_pp0_%0d", i), pp, 0);
    end
    wait_done(16, "hibit");
    init = 1'b0;
    tick();
    start_op(16'd7, 16'd9);
    tick();
    repeat (4) tick();
    init = 1'b0;
    tick();
    init = 1'b1;
    a    = 16'd100;
    wait_done(6, "ignore");
    repeat (20) tick();
    chk("ignore_done_held", done, 1);
    chk("ignore_busy_low", busy, 0);
    chk("ignore_pp_held", pp, 63);
    init = 1'b0;
    tick();
    start_op(16'd5, 16'd2);
    wait_done(0, "b2b_first");
    init = 1'b0;
    tick();
    start_op(16'd6, 16'd7);
    wait_done(0, "b2b_second");
    init = 1'b0;
    tick();
    start_op(16'd11, 16'd13);
    tick();
    repeat (8) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_pp", pp, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    exp_q.push_back(32'd143);
    wait_done(0, "after_rst");
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
